// File: rtl/s10sl3_pkg.sv
// Shared types and default sizing for the SerialLite III TX packetiser.
package s10sl3_pkg;

    localparam int DEF_WIDTH   = 64;
    localparam int DEF_BURST   = 8;
    localparam int DEF_TIMEOUT = 32;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 sop;
        logic                 eop;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        DRAIN
    } state_t;

endpackage

// File: rtl/s10sl3_tx_outreg.sv
// Output beat register: loads a released beat and holds it stable until the sink accepts it.
module s10sl3_tx_outreg
    import s10sl3_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             sop_i,
    input  logic             eop_i,
    input  logic             tx_ready_i,
    output logic             free_o,
    output logic [WIDTH-1:0] tx_data_o,
    output logic             tx_valid_o,
    output logic             tx_sop_o,
    output logic             tx_eop_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;

    assign free_o = !vld_q || tx_ready_i;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        sop_d  = sop_q;
        eop_d  = eop_q;
        if (load_i) begin
            data_d = data_i;
            vld_d  = 1'b1;
            sop_d  = sop_i;
            eop_d  = eop_i;
        end else if (free_o) begin
            // data is left in place; only the qualifiers drop
            vld_d = 1'b0;
            sop_d = 1'b0;
            eop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            sop_q  <= sop_d;
            eop_q  <= eop_d;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_valid_o = vld_q;
    assign tx_sop_o   = sop_q;
    assign tx_eop_o   = eop_q;

endmodule

// File: rtl/s10_sl3_tx_packer.sv
// Drains a show-ahead FIFO into sop/eop-framed packets of up to BURST beats with idle timeout.
// Optional S10_SL3_TX_PACKER_STATS_EN adds beat/packet/timeout counters.
module s10_sl3_tx_packer
    import s10sl3_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BURST   = DEF_BURST,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             fifo_rdempty_n,
    output logic             fifo_rdreq,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    output logic             tx_sop,
    output logic             tx_eop,
    input  logic             tx_ready
`ifdef S10_SL3_TX_PACKER_STATS_EN
    ,
    output logic [31:0]      stat_beats,
    output logic [31:0]      stat_packets,
    output logic [31:0]      stat_timeouts
`endif
);

    localparam int CNT_W = $clog2(BURST);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    state_t           state_q;
    logic [WIDTH-1:0] h_data_q;
    logic             h_sop_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TMR_W-1:0] tmr_q;

    logic h_vld, o_free, at_last, at_tmo, release_h, rel_eop, pop, new_pkt;

    assign h_vld     = (state_q == OPEN);
    assign at_last   = (cnt_q == CNT_LAST);
    assign at_tmo    = (tmr_q == TMR_MAX);
    assign release_h = h_vld && o_free && (fifo_rdempty_n || at_last || at_tmo);
    // a word arriving exactly at timeout keeps the packet open
    assign rel_eop   = at_last || (at_tmo && !fifo_rdempty_n);
    assign pop       = fifo_rdempty_n && !rst && (!h_vld || release_h);
    assign new_pkt   = (state_q == IDLE) || (release_h && rel_eop);

    assign fifo_rdreq = pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            h_data_q <= '0;
            h_sop_q  <= 1'b0;
            cnt_q    <= '0;
            tmr_q    <= '0;
        end else if (pop) begin
            h_data_q <= fifo_q;
            h_sop_q  <= new_pkt;
            cnt_q    <= new_pkt ? '0 : cnt_q + CNT_W'(1);
            tmr_q    <= '0;
            state_q  <= OPEN;
        end else if (release_h) begin
            state_q <= rel_eop ? IDLE : DRAIN;
        end else if (h_vld && !at_tmo) begin
            tmr_q <= tmr_q + TMR_W'(1);
        end
    end

    s10sl3_tx_outreg #(
        .WIDTH(WIDTH)
    ) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (release_h),
        .data_i     (h_data_q),
        .sop_i      (h_sop_q),
        .eop_i      (rel_eop),
        .tx_ready_i (tx_ready),
        .free_o     (o_free),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_sop_o   (tx_sop),
        .tx_eop_o   (tx_eop)
    );

`ifdef S10_SL3_TX_PACKER_STATS_EN
    // remembers whether the beat sitting in O was closed by the idle timer
    logic o_tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_tmo_q       <= 1'b0;
            stat_beats    <= '0;
            stat_packets  <= '0;
            stat_timeouts <= '0;
        end else begin
            if (release_h) o_tmo_q <= rel_eop && !at_last;
            if (tx_valid && tx_ready) begin
                stat_beats <= stat_beats + 32'd1;
                if (tx_eop) stat_packets <= stat_packets + 32'd1;
                if (tx_eop && o_tmo_q) stat_timeouts <= stat_timeouts + 32'd1;
            end
        end
    end
`endif

endmodule
